// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM state type and AXI read constants for the DMA read engine
package dma_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int MAX_BURST_LEN = 256;
endpackage

// File: rtl/dma_axi_read_engine.sv
// dma_axi_read_engine: issues one AXI4 INCR read per config entry and streams the beats out
// Optional response/last checking on err is built only with DMA_RD_ERR_CHECK_EN defined.
module dma_axi_read_engine
  import dma_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int CONFIG_LEN_WIDTH = 9,
  parameter int AXI_SIZE         = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [CONFIG_LEN_WIDTH-1:0] cfg_len,
  input  logic [AXI_ADDR_WIDTH-1:0]   cfg_addr,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]                  m_arlen,
  output logic [2:0]                  m_arsize,
  output logic [1:0]                  m_arburst,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [AXI_DATA_WIDTH-1:0]   out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        err
);
  state_e                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                arlen_q;
  logic [8:0]                cnt_q;
  logic                      in_data, beat, last;
  assign in_data = state_q == DATA;
  assign beat    = in_data & m_rvalid & out_ready;
  assign last    = in_data & (cnt_q == 9'd1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      arlen_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (cfg_valid && cfg_len != '0) begin
          addr_q  <= cfg_addr;
          arlen_q <= (32'(cfg_len) > MAX_BURST_LEN) ? 8'hFF : 8'(cfg_len - CONFIG_LEN_WIDTH'(1));
          state_q <= ADDR;
        end
        ADDR: if (m_arready) begin
          cnt_q   <= {1'b0, arlen_q} + 9'd1;
          state_q <= DATA;
        end
        DATA: if (beat) begin
          cnt_q <= cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // cfg_ready is gated by rst_n so it reads 0 while reset is held
  assign cfg_ready = rst_n & (state_q == IDLE);
  assign m_arvalid = state_q == ADDR;
  assign m_araddr  = addr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = rst_n ? 3'(AXI_SIZE) : 3'b0;
  assign m_arburst = rst_n ? AXI_BURST_INCR : 2'b0;
  assign m_rready  = in_data & out_ready;
  assign out_valid = in_data & m_rvalid;
  assign out_data  = in_data ? m_rdata : '0;
  assign out_last  = last;
  assign busy      = state_q != IDLE;
`ifdef DMA_RD_ERR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (beat && (m_rresp != 2'b00 || m_rlast != last)) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = ^{m_rresp, m_rlast};
  assign err = 1'b0;
`endif
endmodule
